imem_arbiter: RTL and testbench

- Owns the single port of the instruction memory (program ROM/RAM) and shares it between the CPU fetch stage and the UART program loader.
- In normal operation the fetch stage has exclusive read access.
- On a loader request, the block drains the outstanding fetch read, holds the CPU, and grants the port to the loader for word writes.
- When loading ends, it pulses a CPU restart so fetch resumes from PC 0.

---
 rtl/imem_arbiter.sv | 131 +++++++++++++
 tb/tb_imem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: fetch reads in RUN, loader writes in LOAD,
// with a one-cycle drain on the way in and a CPU restart pulse on the way out.
module imem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 50000000,
    parameter int CNT_W   = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              fetch_stall,
    input  logic              ld_req,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_grant,
    output logic              ld_ack,
    output logic              ld_err,
    output logic [ADDR_W:0]   ld_count,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_LOAD    = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]  COUNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic             pend;
    logic [CNT_W-1:0] timer;
    logic             timeout_hit;

    // A write in the final idle slot re-arms the timer instead of aborting.
    assign timeout_hit = (timer == TIMER_LAST) && !ld_wr;

    assign fetch_valid = pend;
    assign fetch_data  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:     if (ld_req) state_next = S_DRAIN;
            S_DRAIN:   state_next = ld_req ? S_LOAD : S_RUN;
            S_LOAD:    if (ld_done || timeout_hit) state_next = S_RESTART;
            S_RESTART: state_next = S_RUN;
            default:   state_next = S_RUN;
        endcase
    end

    always_comb begin
        fetch_stall = 1'b1;
        cpu_hold    = 1'b1;
        ld_grant    = 1'b0;
        cpu_restart = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            S_RUN: begin
                fetch_stall = 1'b0;
                cpu_hold    = 1'b0;
                mem_en      = fetch_req;
                mem_addr    = fetch_addr;
            end
            S_LOAD: begin
                ld_grant  = 1'b1;
                mem_en    = ld_wr;
                mem_we    = ld_wr;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
            end
            S_RESTART: cpu_restart = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            ld_ack   <= 1'b0;
            ld_err   <= 1'b0;
            ld_count <= '0;
            timer    <= '0;
        end else begin
            pend   <= mem_en & ~mem_we;
            ld_ack <= (state == S_LOAD) & ld_wr;
            // Session bookkeeping restarts on the DRAIN->LOAD edge.
            if (state == S_DRAIN && ld_req) begin
                ld_count <= '0;
                ld_err   <= 1'b0;
                timer    <= '0;
            end else if (state == S_LOAD) begin
                if (ld_wr) begin
                    timer <= '0;
                    if (ld_count != COUNT_MAX) ld_count <= ld_count + COUNT_ONE;
                end else begin
                    timer <= timer + TIMER_ONE;
                    if (timeout_hit && !ld_done) ld_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed sessions plus randomized loads, checked
// against an expected memory image and per-session expectations.
module tb_imem_arbiter;

    localparam int AW    = 4;
    localparam int TO    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
    logic          fetch_stall;
    logic          ld_req;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          ld_grant;
    logic          ld_ack;
    logic          ld_err;
    logic [AW:0]   ld_count;
    logic          cpu_hold;
    logic          cpu_restart;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_init;

    imem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_stall(fetch_stall),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_grant(ld_grant), .ld_ack(ld_ack), .ld_err(ld_err),
        .ld_count(ld_count), .cpu_hold(cpu_hold), .cpu_restart(cpu_restart),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010001);
    endfunction

    // Single-port memory with one-cycle read latency
    logic [31:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= pattern(i);
        end else if (mem_en && mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
    end

    // Scoreboard state
    logic [31:0]   exp_q[$];
    logic [31:0]   ref_mem [DEPTH];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            errors = 0;
    int            checks = 0;
    int            exp_cnt = 0;
    bit            exp_err = 1'b0;
    bit            prev_wr = 1'b0;
    bit            rd_issued = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch_ret();
        chk("fetch_valid", 32'(fetch_valid), 32'(rd_issued));
        if (rd_issued) chk("fetch_data", fetch_data, exp_q.pop_front());
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_fetch_valid"}, 32'(fetch_valid), 0);
        chk({tag, "_fetch_stall"}, 32'(fetch_stall), 0);
        chk({tag, "_ld_grant"}, 32'(ld_grant), 0);
        chk({tag, "_ld_ack"}, 32'(ld_ack), 0);
        chk({tag, "_ld_err"}, 32'(ld_err), 0);
        chk({tag, "_ld_count"}, 32'(ld_count), 0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_cpu_restart"}, 32'(cpu_restart), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Driver tasks
    task automatic run_cycle_fetch(input bit req, input logic [AW-1:0] a);
        fetch_req = req; fetch_addr = a; ld_req = 1'b0; ld_wr = 1'b0; ld_done = 1'b0;
        #1;
        chk_fetch_ret();
        chk("run_stall", 32'(fetch_stall), 0);
        chk("run_hold", 32'(cpu_hold), 0);
        chk("run_grant", 32'(ld_grant), 0);
        chk("run_restart", 32'(cpu_restart), 0);
        chk("run_ack", 32'(ld_ack), 0);
        chk("run_mem_en", 32'(mem_en), 32'(req));
        chk("run_mem_we", 32'(mem_we), 0);
        if (req) chk("run_mem_addr", 32'(mem_addr), 32'(a));
        chk("run_count_hold", 32'(ld_count), exp_cnt);
        chk("run_err_hold", 32'(ld_err), 32'(exp_err));
        rd_issued = req;
        if (req) exp_q.push_back(ref_mem[a]);
        next();
    endtask

    task automatic enter_load(input logic [AW-1:0] fa);
        ld_req = 1'b1; ld_wr = 1'b0; ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = fa;
        #1;
        chk_fetch_ret();
        chk("req_stall", 32'(fetch_stall), 0);
        chk("req_mem_en", 32'(mem_en), 1);
        chk("req_mem_addr", 32'(mem_addr), 32'(fa));
        chk("req_count_hold", 32'(ld_count), exp_cnt);
        chk("req_err_hold", 32'(ld_err), 32'(exp_err));
        rd_issued = 1'b1;
        exp_q.push_back(ref_mem[fa]);
        next();
        fetch_addr = ~fa;
        #1;
        chk_fetch_ret();
        chk("drain_stall", 32'(fetch_stall), 1);
        chk("drain_hold", 32'(cpu_hold), 1);
        chk("drain_grant", 32'(ld_grant), 0);
        chk("drain_restart", 32'(cpu_restart), 0);
        chk("drain_mem_en", 32'(mem_en), 0);
        rd_issued = 1'b0;
        next();
        exp_cnt = 0; exp_err = 1'b0; prev_wr = 1'b0;
    endtask

    task automatic load_idle();
        ld_wr = 1'b0; ld_done = 1'b0;
        ld_req = 1'($urandom_range(0, 1));
        fetch_req = 1'($urandom_range(0, 1));
        ld_addr = AW'($urandom_range(0, DEPTH - 1));
        #1;
        chk_fetch_ret();
        chk("load_grant", 32'(ld_grant), 1);
        chk("load_stall", 32'(fetch_stall), 1);
        chk("load_hold", 32'(cpu_hold), 1);
        chk("load_restart", 32'(cpu_restart), 0);
        chk("load_idle_mem_en", 32'(mem_en), 0);
        chk("load_ack", 32'(ld_ack), 32'(prev_wr));
        chk("load_count", 32'(ld_count), exp_cnt);
        chk("load_err", 32'(ld_err), 0);
        prev_wr = 1'b0;
        next();
    endtask

    task automatic load_write(input logic [AW-1:0] a, input logic [31:0] d, input bit done);
        ld_wr = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
        ld_req = 1'($urandom_range(0, 1));
        fetch_req = 1'($urandom_range(0, 1));
        #1;
        chk_fetch_ret();
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'(a));
        chk("wr_mem_wdata", mem_wdata, d);
        chk("wr_grant", 32'(ld_grant), 1);
        chk("wr_ack", 32'(ld_ack), 32'(prev_wr));
        chk("wr_count", 32'(ld_count), exp_cnt);
        chk("wr_err", 32'(ld_err), 0);
        ref_mem[a] = d;
        if (exp_cnt < DEPTH) exp_cnt++;
        prev_wr = 1'b1;
        next();
        ld_done = 1'b0;
    endtask

    // Runs one full session using the queued writes.
    task automatic session(input logic [AW-1:0] fa, input bit coll, input bit to,
                           input int max_gap, input int first_gap, input int done_gap,
                           input bit hold_req);
        int n;
        int gap;
        enter_load(fa);
        n = wr_addr_q.size();
        for (int i = 0; i < n; i++) begin
            gap = (i == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, max_gap));
            repeat (gap) load_idle();
            load_write(wr_addr_q[i], wr_data_q[i], coll && (i == n - 1));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        if (to) begin
            repeat (TO) load_idle();
            exp_err = 1'b1;
        end else if (!coll || n == 0) begin
            repeat (done_gap) load_idle();
            ld_wr = 1'b0; ld_done = 1'b1; fetch_req = 1'b0;
            #1;
            chk("done_grant", 32'(ld_grant), 1);
            chk("done_ack", 32'(ld_ack), 32'(prev_wr));
            chk("done_count", 32'(ld_count), exp_cnt);
            prev_wr = 1'b0;
            next();
            ld_done = 1'b0;
        end
        ld_wr = 1'b0; ld_done = 1'b0; ld_req = hold_req; fetch_req = 1'b0;
        #1;
        chk_fetch_ret();
        chk("restart_pulse", 32'(cpu_restart), 1);
        chk("restart_hold", 32'(cpu_hold), 1);
        chk("restart_stall", 32'(fetch_stall), 1);
        chk("restart_grant", 32'(ld_grant), 0);
        chk("restart_mem_en", 32'(mem_en), 0);
        chk("restart_ack", 32'(ld_ack), 32'(prev_wr));
        chk("restart_count", 32'(ld_count), exp_cnt);
        chk("restart_err", 32'(ld_err), 32'(exp_err));
        prev_wr = 1'b0;
        next();
    endtask

    task automatic queue_random_writes(input int n);
        for (int i = 0; i < n; i++) begin
            wr_addr_q.push_back(AW'($urandom_range(0, DEPTH - 1)));
            wr_data_q.push_back($urandom());
        end
    endtask

    task automatic aborted_req();
        fetch_req = 1'b0; ld_req = 1'b1; ld_wr = 1'b0; ld_done = 1'b0;
        #1;
        chk_fetch_ret();
        chk("abort_run_stall", 32'(fetch_stall), 0);
        rd_issued = 1'b0;
        next();
        ld_req = 1'b0;
        #1;
        chk("abort_drain_stall", 32'(fetch_stall), 1);
        chk("abort_drain_grant", 32'(ld_grant), 0);
        chk("abort_drain_restart", 32'(cpu_restart), 0);
        next();
        run_cycle_fetch(1'b0, '0);
        run_cycle_fetch(1'b0, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
        rst = 1'b1; mem_init = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0; ld_req = 1'b0; ld_wr = 1'b0;
        ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        next();
        next();
        rst = 1'b0; mem_init = 1'b0;
        #1;
        chk_quiet("reset");

        // Plain fetch after reset
        run_cycle_fetch(1'b1, 4'd0);
        run_cycle_fetch(1'b1, 4'd1);
        run_cycle_fetch(1'b1, 4'd2);
        run_cycle_fetch(1'b0, 4'd0);

        // Directed load session entered during a fetch to address 5
        wr_addr_q.push_back(4'd0); wr_data_q.push_back(32'h00000013);
        wr_addr_q.push_back(4'd1); wr_data_q.push_back(32'h00100093);
        session(4'd5, 1'b0, 1'b0, 2, -1, 0, 1'b0);
        run_cycle_fetch(1'b1, 4'd0);
        run_cycle_fetch(1'b1, 4'd1);
        run_cycle_fetch(1'b0, 4'd0);

        // Write and done in the same cycle
        wr_addr_q.push_back(4'd3); wr_data_q.push_back(32'hDEADBEEF);
        session(4'd7, 1'b1, 1'b0, 3, -1, 0, 1'b0);
        run_cycle_fetch(1'b1, 4'd3);
        run_cycle_fetch(1'b0, 4'd0);

        // Timeout with no writes, error holds in RUN, next grant clears it
        session(4'd2, 1'b0, 1'b1, 0, -1, 0, 1'b0);
        run_cycle_fetch(1'b1, 4'd4);
        run_cycle_fetch(1'b0, 4'd0);
        queue_random_writes(2);
        session(4'd9, 1'b0, 1'b0, 3, -1, 0, 1'b0);

        // Request withdrawn during DRAIN
        aborted_req();

        // Done lands on the cycle the timer would expire
        session(4'd1, 1'b0, 1'b0, 0, -1, TO - 1, 1'b0);

        // Longest idle gap that must not time out, then timeout after writes
        queue_random_writes(2);
        session(4'd6, 1'b0, 1'b0, 2, TO - 1, 0, 1'b0);
        queue_random_writes(3);
        session(4'd8, 1'b0, 1'b1, 4, -1, 0, 1'b0);

        // Request still high through RESTART starts a new session
        queue_random_writes(1);
        session(4'd10, 1'b0, 1'b0, 2, -1, 0, 1'b1);
        queue_random_writes(2);
        session(4'd11, 1'b1, 1'b0, 2, -1, 0, 1'b0);

        // Count saturates at the memory depth
        queue_random_writes(DEPTH + 2);
        session(4'd12, 1'b0, 1'b0, 0, -1, 0, 1'b0);

        // Randomized sessions interleaved with fetch bursts
        for (int s = 0; s < 8; s++) begin
            int nf;
            bit coll;
            bit to;
            nf = int'($urandom_range(2, 6));
            for (int f = 0; f < nf; f++)
                run_cycle_fetch(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
            queue_random_writes(int'($urandom_range(0, 6)));
            to   = ($urandom_range(0, 3) == 0);
            coll = !to && (wr_addr_q.size() > 0) && 1'($urandom_range(0, 1));
            session(AW'($urandom_range(0, DEPTH - 1)), coll, to, TO - 2, -1,
                    int'($urandom_range(0, 3)), 1'b0);
        end

        // Full readback of the memory image
        for (int a = 0; a < DEPTH; a++) run_cycle_fetch(1'b1, AW'(a));
        run_cycle_fetch(1'b0, '0);

        // Reset in the middle of a session
        enter_load(4'd13);
        for (int i = 0; i < 3; i++)
            load_write(AW'($urandom_range(0, DEPTH - 1)), $urandom(), 1'b0);
        rst = 1'b1; ld_wr = 1'b0; ld_req = 1'b0; ld_done = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        next();
        chk_quiet("midload_reset");
        rst = 1'b0;
        exp_cnt = 0; exp_err = 1'b0; prev_wr = 1'b0; rd_issued = 1'b0;
        exp_q.delete();
        run_cycle_fetch(1'b0, '0);
        run_cycle_fetch(1'b1, 4'd0);
        run_cycle_fetch(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
